// File: rtl/can_bit_sampler_if.sv
// CAN bit sampler bundle: TQ strobe, segment config and RX in; sample/bit-start/edge strobes out.
// master = bit-timing/test side driving the inputs, slave = the sampler.
interface can_bit_sampler_if #(
  parameter int SEG_W = 6
);
  logic             tq_pulse;
  logic [SEG_W-1:0] prop_seg;
  logic [SEG_W-1:0] phase_seg1;
  logic [SEG_W-1:0] phase_seg2;
  logic [SEG_W-1:0] sjw;
  logic             hard_sync_en;
  logic             rx_in;
  logic             sample_pulse;
  logic             rx_bit;
  logic             bit_start;
  logic             edge_seen;

  modport master (
    output tq_pulse, prop_seg, phase_seg1, phase_seg2, sjw, hard_sync_en, rx_in,
    input  sample_pulse, rx_bit, bit_start, edge_seen
  );

  modport slave (
    input  tq_pulse, prop_seg, phase_seg1, phase_seg2, sjw, hard_sync_en, rx_in,
    output sample_pulse, rx_bit, bit_start, edge_seen
  );
endinterface

// File: rtl/can_bit_sampler.sv
// CAN bit position tracker with hard sync/resync; CAN_TRIPLE_SAMPLE_EN selects 3-sample majority.
// Latency: strobes registered one clock after the causing tq_pulse; RX path adds SYNC_FF clocks.
// Backpressure: none; paced entirely by tq_pulse.
module can_bit_sampler #(
  parameter int SEG_W   = 6,
  parameter int SYNC_FF = 2
) (
  input  logic               clk_ref,
  input  logic               rst,
  can_bit_sampler_if.slave   bus
);
  localparam int CW = SEG_W + 2;
  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_TSEG1 = 2'd1;
  localparam logic [1:0] ST_TSEG2 = 2'd2;

  logic [SYNC_FF-1:0] sync_q;
  logic               rx_s;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, ext_q, ext_d, shrink_q, shrink_d;
  logic [CW-1:0]      tseg1_q, ph2_q, sjw_q;
  logic [CW-1:0]      tseg1_in, ph2_in, sjw_in;
  logic [SEG_W:0]     tseg1_raw;
  logic [SEG_W-1:0]   sjw_m;
  logic               resync_done_q, resync_done_d;
  logic               rx_prev_q, rx_prev_d;
  logic               rx_bit_q, rx_bit_d;
  logic               sample_q, sample_d, bit_start_q, bit_start_d, edge_q, edge_d;
  logic [CW-1:0]      cnt_inc, remain;
  logic               edge_det, resync_ok, early_end, sample_val;

  assign rx_s = sync_q[SYNC_FF-1];

  assign bus.sample_pulse = sample_q;
  assign bus.rx_bit       = rx_bit_q;
  assign bus.bit_start    = bit_start_q;
  assign bus.edge_seen    = edge_q;

  always_comb begin
    tseg1_raw = {1'b0, bus.prop_seg} + {1'b0, bus.phase_seg1};
    tseg1_in  = (tseg1_raw == '0) ? CW'(1) : CW'(tseg1_raw);
    ph2_in    = (bus.phase_seg2 == '0) ? CW'(1) : CW'(bus.phase_seg2);
    sjw_m     = bus.sjw;
    if (bus.phase_seg1 < sjw_m) sjw_m = bus.phase_seg1;
    if (bus.phase_seg2 < sjw_m) sjw_m = bus.phase_seg2;
    if (sjw_m == '0) sjw_m = SEG_W'(1);
    sjw_in = CW'(sjw_m);
  end

`ifdef CAN_TRIPLE_SAMPLE_EN
  logic [1:0] maj_q, maj_d;
  always_comb begin
    if (tseg1_q >= CW'(3))
      sample_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
    else
      sample_val = rx_s;
  end
`else
  assign sample_val = rx_s;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ext_d         = ext_q;
    shrink_d      = shrink_q;
    resync_done_d = resync_done_q;
    rx_prev_d     = rx_prev_q;
    rx_bit_d      = rx_bit_q;
    sample_d      = 1'b0;
    bit_start_d   = 1'b0;
    edge_d        = 1'b0;
    early_end     = 1'b0;
    cnt_inc       = cnt_q + CW'(1);
    remain        = ph2_q - cnt_inc;
    edge_det      = bus.tq_pulse && rx_prev_q && !rx_s;
    resync_ok     = edge_det && !bus.hard_sync_en && !resync_done_q && rx_bit_q;
`ifdef CAN_TRIPLE_SAMPLE_EN
    maj_d = maj_q;
`endif
    if (bus.tq_pulse) begin
      rx_prev_d = rx_s;
      edge_d    = edge_det;
      if (edge_det && bus.hard_sync_en) begin
        // Hard sync: behave as if SYNC just completed, no bit_start.
        state_d  = ST_TSEG1;
        cnt_d    = '0;
        ext_d    = '0;
        shrink_d = '0;
      end else begin
        case (state_q)
          ST_SYNC: begin
            state_d  = ST_TSEG1;
            cnt_d    = '0;
            ext_d    = '0;
            shrink_d = '0;
          end
          ST_TSEG1: begin
            cnt_d = cnt_inc;
`ifdef CAN_TRIPLE_SAMPLE_EN
            maj_d = {maj_q[0], rx_s};
`endif
            if (resync_ok) begin
              ext_d         = (cnt_inc < sjw_q) ? cnt_inc : sjw_q;
              resync_done_d = 1'b1;
            end
            if (cnt_inc >= tseg1_q + ext_d) begin
              state_d       = ST_TSEG2;
              cnt_d         = '0;
              sample_d      = 1'b1;
              rx_bit_d      = sample_val;
              resync_done_d = 1'b0;
            end
          end
          ST_TSEG2: begin
            cnt_d = cnt_inc;
            if (resync_ok) begin
              resync_done_d = 1'b1;
              if (remain <= sjw_q) early_end = 1'b1;
              else                 shrink_d  = sjw_q;
            end
            if (early_end || cnt_inc >= ph2_q - shrink_d) begin
              state_d     = ST_SYNC;
              cnt_d       = '0;
              bit_start_d = 1'b1;
            end
          end
          default: begin
            state_d = ST_SYNC;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      sync_q        <= '1;
      state_q       <= ST_SYNC;
      cnt_q         <= '0;
      ext_q         <= '0;
      shrink_q      <= '0;
      resync_done_q <= 1'b0;
      rx_prev_q     <= 1'b1;
      rx_bit_q      <= 1'b1;
      sample_q      <= 1'b0;
      bit_start_q   <= 1'b0;
      edge_q        <= 1'b0;
      tseg1_q       <= CW'(1);
      ph2_q         <= CW'(1);
      sjw_q         <= CW'(1);
    end else begin
      sync_q        <= {sync_q[SYNC_FF-2:0], bus.rx_in};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ext_q         <= ext_d;
      shrink_q      <= shrink_d;
      resync_done_q <= resync_done_d;
      rx_prev_q     <= rx_prev_d;
      rx_bit_q      <= rx_bit_d;
      sample_q      <= sample_d;
      bit_start_q   <= bit_start_d;
      edge_q        <= edge_d;
      // Segment config is frozen for the whole bit; it reloads only while sitting in SYNC.
      if (state_q == ST_SYNC) begin
        tseg1_q <= tseg1_in;
        ph2_q   <= ph2_in;
        sjw_q   <= sjw_in;
      end
    end
  end

`ifdef CAN_TRIPLE_SAMPLE_EN
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) maj_q <= 2'b11;
    else     maj_q <= maj_d;
  end
`endif
endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: expected strobes (by TQ index) are queued, then matched as the DUT emits them.
module tb_can_bit_sampler;
`ifdef CAN_TRIPLE_SAMPLE_EN
  localparam logic GLITCH_BIT = 1'b1;
`else
  localparam logic GLITCH_BIT = 1'b0;
`endif

  typedef struct {
    int   tick;
    logic bitv;
  } samp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   seen = 0;
  int   bq[$];
  int   eq[$];
  samp_t sq[$];
  int   mon_t;
  samp_t mon_s;

  can_bit_sampler_if #(.SEG_W(6)) bus ();

  can_bit_sampler #(.SEG_W(6), .SYNC_FF(2)) dut (
    .clk_ref (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // TQ index of the most recent tq_pulse the DUT has taken (stimulus time base).
  always @(posedge clk) begin
    if (rst)               seen <= 0;
    else if (bus.tq_pulse) seen <= seen + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.edge_seen) begin
        check("edge_expected", eq.size() > 0, 1);
        if (eq.size() > 0) begin
          mon_t = eq.pop_front();
          check("edge_tick", seen, mon_t);
        end
      end
      if (bus.bit_start) begin
        check("bit_start_expected", bq.size() > 0, 1);
        if (bq.size() > 0) begin
          mon_t = bq.pop_front();
          check("bit_start_tick", seen, mon_t);
        end
      end
      if (bus.sample_pulse) begin
        check("sample_expected", sq.size() > 0, 1);
        if (sq.size() > 0) begin
          mon_s = sq.pop_front();
          check("sample_tick", seen, mon_s.tick);
          check("rx_bit", bus.rx_bit, mon_s.bitv);
        end
      end
    end
  end

  task automatic tick(input int p);
    repeat (p - 1) @(posedge clk);
    #1 bus.tq_pulse = 1'b1;
    @(posedge clk);
    #1 bus.tq_pulse = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (seen < t) tick(4);
  endtask

  task automatic push_s(input int t, input logic v);
    samp_t s;
    s.tick = t;
    s.bitv = v;
    sq.push_back(s);
  endtask

  initial begin
    bus.tq_pulse     = 1'b0;
    bus.prop_seg     = 6'd2;
    bus.phase_seg1   = 6'd3;
    bus.phase_seg2   = 6'd3;
    bus.sjw          = 6'd1;
    bus.hard_sync_en = 1'b0;
    bus.rx_in        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_pulse", bus.sample_pulse, 0);
    check("rst_bit_start", bus.bit_start, 0);
    check("rst_edge_seen", bus.edge_seen, 0);
    check("rst_rx_bit", bus.rx_bit, 1);
    rst = 1'b0;

    // Nominal 9-TQ bits, recessive line.
    for (int k = 0; k < 3; k++) begin
      push_s(9 * k + 6, 1'b1);
      bq.push_back(9 * k + 9);
    end
    run_to(27);

    // Resync, SJW 1, edge at TSEG1 count 2: 10-TQ bit. SJW change waits for next SYNC.
    eq.push_back(30); push_s(34, 1'b1); bq.push_back(37);
    run_to(29); bus.rx_in = 1'b0;
    run_to(30); bus.rx_in = 1'b1; bus.sjw = 6'd4;
    run_to(37);

    // SJW 4 (effective 3), edge at count 2: 11-TQ bit.
    eq.push_back(40); push_s(45, 1'b1); bq.push_back(48);
    run_to(39); bus.rx_in = 1'b0;
    run_to(40); bus.rx_in = 1'b1; bus.sjw = 6'd2;
    run_to(48);

    // SJW 2, edge with 1 TQ left in TSEG2: early SYNC; second edge before sample ignored.
    push_s(54, 1'b1); eq.push_back(56); bq.push_back(56);
    eq.push_back(59); push_s(62, 1'b1); bq.push_back(65);
    run_to(55); bus.rx_in = 1'b0;
    run_to(56); bus.rx_in = 1'b1;
    run_to(58); bus.rx_in = 1'b0;
    run_to(59); bus.rx_in = 1'b1;
    run_to(65);

    // Edge in SYNC: no adjustment. Then rx_bit=0 blocks resync of a TSEG1 edge.
    eq.push_back(66); push_s(71, 1'b0); bq.push_back(74);
    eq.push_back(77); push_s(80, 1'b1); bq.push_back(83);
    bus.rx_in = 1'b0;
    run_to(74); bus.rx_in = 1'b1;
    run_to(76); bus.rx_in = 1'b0;
    run_to(77); bus.rx_in = 1'b1;
    run_to(83);

    // Hard sync mid-TSEG2: sample 5 TQ later, the pending bit_start is dropped.
    bus.hard_sync_en = 1'b1;
    push_s(89, 1'b1); eq.push_back(91); push_s(96, 1'b0); bq.push_back(99);
    run_to(90); bus.rx_in = 1'b0;
    run_to(96); bus.rx_in = 1'b1; bus.hard_sync_en = 1'b0;
    run_to(99);

    // One-TQ dominant glitch on the last TSEG1 TQ.
    eq.push_back(105); push_s(105, GLITCH_BIT); bq.push_back(108);
    run_to(104); bus.rx_in = 1'b0;
    run_to(105); bus.rx_in = 1'b1;
    run_to(111);

    // Reset at TSEG1 count 2 with tq_pulse held high.
    rst = 1'b1;
    bus.tq_pulse = 1'b1;
    #1;
    check("mid_rst_sample_pulse", bus.sample_pulse, 0);
    check("mid_rst_bit_start", bus.bit_start, 0);
    check("mid_rst_edge_seen", bus.edge_seen, 0);
    check("mid_rst_rx_bit", bus.rx_bit, 1);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_sample_pulse", bus.sample_pulse, 0);
    check("held_rst_rx_bit", bus.rx_bit, 1);
    rst = 1'b0;

    // Restart from SYNC with one TQ per clock.
    push_s(6, 1'b1); bq.push_back(9); push_s(15, 1'b1); bq.push_back(18);
    for (int i = 0; i < 200 && seen < 18; i++) tick(1);
    repeat (4) @(posedge clk);
    #1;

    check("edge_left", eq.size(), 0);
    check("bit_start_left", bq.size(), 0);
    check("sample_left", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
